serial_addsub: RTL and testbench

Bit-serial two's-complement adder/subtractor for the datapath lab. A single full-adder cell and one carry flip-flop process one bit per clock, LSB first. Operands are loaded in parallel through a start/ready handshake, and the result is returned in parallel with a one-cycle `done` pulse. It is the sequential, area-minimal counterpart of the combinational ripple adders and adds the subtract direction (A − B) on the same cell.

---
 rtl/serial_addsub.sv | 151 +++++++++++++++
 tb/tb_serial_addsub.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial two's-complement adder/subtractor. One full-adder cell and one
// carry flip-flop process a single bit per clock, LSB first. Operands are
// loaded in parallel through a start/ready handshake. The result is returned
// in parallel, together with a one-cycle done pulse.
//
// Subtraction computes A - B as A + ~B + 1. The "+1" is injected by presetting
// the carry flip-flop to 1 on accept.
//
// Optional feature macro: SERIAL_ADDSUB_OVF_EN
//   defined     : the carry into the MSB is compared with the carry out of the
//                 MSB, and ovf reports signed overflow of the completed result.
//   not defined : there is no overflow logic, and ovf is tied to 0.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high reset
//   start  in   begin an operation (sampled only while ready = 1)
//   sub    in   0: A+B, 1: A-B (captured with the operands)
//   a      in   operand A [WIDTH]
//   b      in   operand B [WIDTH]
//   ready  out  idle; a start is accepted at the next edge
//   busy   out  operation in progress
//   done   out  one-cycle pulse, y/cout/ovf newly valid
//   y      out  result, A+/-B mod 2^WIDTH [WIDTH]
//   cout   out  carry out of the MSB (for subtraction, 1 = no borrow)
//   ovf    out  signed overflow (0 when the feature is disabled)
// -----------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] sa;     // operand A shift register
    logic [WIDTH-1:0] sb;     // operand B (or ~B) shift register
    logic [WIDTH-1:0] r;      // partial result, filled from the MSB side
    logic             c;      // running carry
    logic [CW-1:0]    cnt;    // index of the bit being processed

    // Full-adder cell.
    logic s;
    logic c_next;
    logic last;

    always_comb begin
        s      = sa[0] ^ sb[0] ^ c;
        c_next = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
        last   = (cnt == LAST_BIT);
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the values from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            y     <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf   <= 1'b0;
`endif
            sa    <= '0;
            sb    <= '0;
            r     <= '0;
            c     <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= sub ? ~b : b;
                        c     <= sub;      // +1 of the two's-complement negate
                        cnt   <= '0;
                        state <= RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end

                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    c   <= c_next;
                    r   <= {s, r[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        // The final sum bit is not yet in r, so it is merged
                        // in here on its way to the output.
                        y     <= {s, r[WIDTH-1:1]};
                        cout  <= c_next;
`ifdef SERIAL_ADDSUB_OVF_EN
                        // c is still the carry into the MSB on this edge.
                        ovf   <= c ^ c_next;
`endif
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifndef SERIAL_ADDSUB_OVF_EN
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//
// Directed testbench for serial_addsub. It drives a WIDTH=8 instance and a
// WIDTH=2 instance, which share the clock and reset. Inputs are driven 1 time
// unit after the rising edge, and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

`ifdef SERIAL_ADDSUB_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ready8, busy8, done8, cout8, ovf8;
    logic [7:0] y8;

    logic       start2 = 1'b0, sub2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       ready2, busy2, done2, cout2, ovf2;
    logic [1:0] y2;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub8),
        .a(a8), .b(b8), .ready(ready8), .busy(busy8), .done(done8),
        .y(y8), .cout(cout8), .ovf(ovf8)
    );

    serial_addsub #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .sub(sub2),
        .a(a2), .b(b2), .ready(ready2), .busy(busy2), .done(done2),
        .y(y2), .cout(cout2), .ovf(ovf2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for done on the 8-bit instance. lat enters holding the number of
    // cycles already spent after accept, and it returns the total.
    task automatic wait_done8(inout int lat);
        while (!done8 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Run one full operation on the 8-bit instance, then check the result and
    // the handshake around it.
    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic ts, input logic [7:0] ey, input logic ec, input logic eo);
        int lat;
        check({tag, " ready before"}, 32'(ready8), 32'd1);
        a8 = ta; b8 = tb; sub8 = ts; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check({tag, " busy"}, 32'(busy8), 32'd1);
        lat = 0;
        wait_done8(lat);
        check({tag, " latency"}, 32'(lat), 32'd8);
        check({tag, " y"}, 32'(y8), 32'(ey));
        check({tag, " cout"}, 32'(cout8), 32'(ec));
        check({tag, " ovf"}, 32'(ovf8), 32'(eo));
        tick();
        check({tag, " done pulse"}, 32'(done8), 32'd0);
        check({tag, " ready after"}, 32'(ready8), 32'd1);
    endtask

    task automatic op2(input string tag, input logic [1:0] ta, input logic [1:0] tb,
                       input logic ts, input logic [1:0] ey, input logic ec, input logic eo);
        int lat;
        a2 = ta; b2 = tb; sub2 = ts; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd2);
        check({tag, " y"}, 32'(y2), 32'(ey));
        check({tag, " cout"}, 32'(cout2), 32'(ec));
        check({tag, " ovf"}, 32'(ovf2), 32'(eo));
        tick();
        check({tag, " ready after"}, 32'(ready2), 32'd1);
    endtask

    initial begin
        int  lat;
        logic seen_done;

        // Reset state.
        #1 reset = 1'b1;
        #1;
        check("rst ready", 32'(ready8), 32'd1);
        check("rst busy",  32'(busy8),  32'd0);
        check("rst done",  32'(done8),  32'd0);
        check("rst y",     32'(y8),     32'd0);
        check("rst cout",  32'(cout8),  32'd0);
        check("rst ovf",   32'(ovf8),   32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Additions and subtractions with hand-computed results.
        op8("add 3c+25", 8'h3C, 8'h25, 1'b0, 8'h61, 1'b0, 1'b0);
        op8("add 7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF_ON);
        op8("add ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("sub 05-07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("sub 00-00", 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        op8("sub 80-01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, OVF_ON);

        // Input changes and a held start during RUN are ignored. The previous
        // result stays visible until the completion edge.
        a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
        tick();
        check("hold busy", 32'(busy8), 32'd1);
        a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;   // start8 stays high
        tick(); tick(); tick();
        check("hold y old",    32'(y8),     32'h7F);
        check("hold cout old", 32'(cout8),  32'd1);
        check("hold ready",    32'(ready8), 32'd0);
        lat = 3;
        wait_done8(lat);
        check("hold latency", 32'(lat),    32'd8);
        check("hold y",       32'(y8),     32'h30);
        check("hold cout",    32'(cout8),  32'd0);
        check("hold ovf",     32'(ovf8),   32'd0);
        check("hold done rdy", 32'(ready8), 32'd0);
        tick();
        check("hold idle ready", 32'(ready8), 32'd1);
        check("hold idle busy",  32'(busy8),  32'd0);
        tick();
        check("second accept", 32'(busy8), 32'd1);
        start8 = 1'b0;
        lat = 0;
        wait_done8(lat);
        check("second latency", 32'(lat),   32'd8);
        check("second y",       32'(y8),    32'h00);
        check("second cout",    32'(cout8), 32'd1);
        tick();

        op8("add 22+11", 8'h22, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0);

        // Reset asserted during the third RUN cycle.
        a8 = 8'h44; b8 = 8'h11; sub8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        check("mid busy",  32'(busy8), 32'd1);
        check("mid y old", 32'(y8),    32'h33);
        reset = 1'b1;
        #1;
        check("arst y",     32'(y8),     32'd0);
        check("arst cout",  32'(cout8),  32'd0);
        check("arst ovf",   32'(ovf8),   32'd0);
        check("arst busy",  32'(busy8),  32'd0);
        check("arst done",  32'(done8),  32'd0);
        check("arst ready", 32'(ready8), 32'd1);
        tick();
        reset = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) seen_done = 1'b1;
        end
        check("no done after rst", 32'(seen_done), 32'd0);
        op8("add 01+02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // WIDTH=2 instance.
        op2("w2 add 3+1", 2'b11, 2'b01, 1'b0, 2'b00, 1'b1, 1'b0);
        op2("w2 add 1+1", 2'b01, 2'b01, 1'b0, 2'b10, 1'b0, OVF_ON);
        op2("w2 sub 1-2", 2'b01, 2'b10, 1'b1, 2'b11, 1'b0, OVF_ON);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
